// File: rtl/step_dir_gen.sv
// Step/dir pulse generator: turns (signed step count, period) commands into
// dir plus fixed-width step pulses, with dir setup time and a position count.
module step_dir_gen #(
  parameter int STEPS_WIDTH  = 32,
  parameter int PERIOD_WIDTH = 24,
  parameter int POS_WIDTH    = 32,
  parameter int PULSE_LEN    = 2,
  parameter int DIR_SETUP    = 4
) (
  input  logic                           clk,
  input  logic                           aclr,
  input  logic                           sclr,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic signed [STEPS_WIDTH-1:0]  cmd_steps,
  input  logic        [PERIOD_WIDTH-1:0] cmd_period,
  output logic                           step,
  output logic                           dir,
  output logic                           busy,
  output logic                           done,
  output logic                           aborted,
  output logic        [STEPS_WIDTH-1:0]  remain,
  output logic signed [POS_WIDTH-1:0]    pos
);

  localparam int CW = PERIOD_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_HIGH  = 2'd2;
  localparam logic [1:0] S_LOW   = 2'd3;

  localparam logic [CW-1:0] MIN_PERIOD = CW'(2 * PULSE_LEN);
  localparam logic [CW-1:0] PULSE_C    = CW'(PULSE_LEN);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(DIR_SETUP - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [STEPS_WIDTH-1:0]     REM_ONE = STEPS_WIDTH'(1);
  localparam logic signed [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

  // Magnitude of the signed count; the most negative value maps to 2^(W-1).
  function automatic logic [STEPS_WIDTH-1:0] abs_steps(input logic signed [STEPS_WIDTH-1:0] s);
    logic [STEPS_WIDTH-1:0] u;
    u = $unsigned(s);
    return s[STEPS_WIDTH-1] ? (~u + REM_ONE) : u;
  endfunction

  function automatic logic [CW-1:0] eff_period(input logic [PERIOD_WIDTH-1:0] p);
    logic [CW-1:0] pe;
    pe = {1'b0, p};
    return (pe < MIN_PERIOD) ? MIN_PERIOD : pe;
  endfunction

  logic [1:0]                    state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CW-1:0]                 period_q, period_d;
  logic                          step_q, step_d;
  logic                          dir_q, dir_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          abrt_q, abrt_d;
  logic                          pend_q, pend_d;
  logic        [STEPS_WIDTH-1:0] remain_q, remain_d;
  logic signed [POS_WIDTH-1:0]   pos_q, pos_d;
  logic                          accept;
  logic                          do_rise;
  logic                          do_abort;

  assign cmd_ready = (state_q == S_IDLE) && !sclr;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    step_d   = step_q;
    dir_d    = dir_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    abrt_d   = 1'b0;
    pend_d   = pend_q;
    remain_d = remain_q;
    pos_d    = pos_q;
    do_rise  = 1'b0;
    do_abort = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_steps == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_SETUP;
            dir_d    = cmd_steps[STEPS_WIDTH-1];
            remain_d = abs_steps(cmd_steps);
            period_d = eff_period(cmd_period);
            cnt_d    = SETUP_LAST;
            busy_d   = 1'b1;
            pend_d   = 1'b0;
          end
        end
      end
      S_SETUP: begin
        if (sclr)              do_abort = 1'b1;
        else if (cnt_q == '0)  do_rise  = 1'b1;
        else                   cnt_d    = cnt_q - CNT_ONE;
      end
      // An abort seen mid-pulse is held in pend_q so the pulse keeps its full width.
      S_HIGH: begin
        if (cnt_q == '0) begin
          if (pend_q || sclr) begin
            do_abort = 1'b1;
          end else begin
            state_d = S_LOW;
            step_d  = 1'b0;
            cnt_d   = period_q - PULSE_C - CNT_ONE;
          end
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          pend_d = pend_q | sclr;
        end
      end
      S_LOW: begin
        if (sclr) begin
          do_abort = 1'b1;
        end else if (cnt_q == '0) begin
          if (remain_q != '0) begin
            do_rise = 1'b1;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_rise) begin
      state_d  = S_HIGH;
      step_d   = 1'b1;
      cnt_d    = PULSE_LAST;
      pend_d   = 1'b0;
      remain_d = remain_q - REM_ONE;
      pos_d    = dir_q ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
    end
    if (do_abort) begin
      state_d  = S_IDLE;
      step_d   = 1'b0;
      busy_d   = 1'b0;
      pend_d   = 1'b0;
      remain_d = '0;
      abrt_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abrt_q   <= 1'b0;
      pend_q   <= 1'b0;
      remain_q <= '0;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      abrt_q   <= abrt_d;
      pend_q   <= pend_d;
      remain_q <= remain_d;
      pos_q    <= pos_d;
    end
  end

  // Period is only consumed outside IDLE, after being loaded on accept.
  always_ff @(posedge clk) begin
    period_q <= period_d;
  end

  assign step    = step_q;
  assign dir     = dir_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = abrt_q;
  assign remain  = remain_q;
  assign pos     = pos_q;

endmodule

// File: doc/step_dir_gen.md
# step_dir_gen

Step/dir pulse generator: the transmit end of the step/dir motor interface. Accepts move commands (signed step count, step period in clocks) over a valid/ready handshake. Drives `dir` with a guaranteed setup time and `step` pulses of fixed width at the commanded rate. Keeps a signed position count of emitted steps. It sits between the trajectory/command logic and the motor-driver step/dir pins, or the on-chip phase decoder.

## Interface
- `STEPS_WIDTH`, 32: width of signed `cmd_steps` and of `remain`.
- `PERIOD_WIDTH`, 24: width of unsigned `cmd_period`.
- `POS_WIDTH`, 32: width of signed `pos`.
- `PULSE_LEN`, 2: `step` high time in clocks; must be ≥1.
- `DIR_SETUP`, 4: clocks between `dir` update and the first `step` rise; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `aclr`  in  1  reset: asynchronous, active-high.
- `sclr`  in  1  synchronous abort, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready`.
- `cmd_steps`  in  STEPS_WIDTH  signed step count; sign selects direction.
- `cmd_period`  in  PERIOD_WIDTH  step period in clocks.
- `step`  out  1  step pulse, registered.
- `dir`  out  1  direction, registered: 0 = positive (count up), 1 = negative.
- `busy`  out  1  command in progress.
- `done`  out  1  one-clock pulse on normal completion.
- `aborted`  out  1  one-clock pulse when a command ends due to `sclr`.
- `remain`  out  STEPS_WIDTH  unsigned steps not yet started.
- `pos`  out  POS_WIDTH  signed position count; wraps two's complement.

## Operation
- States: IDLE, SETUP, HIGH, LOW.
- `cmd_ready` = (state == IDLE) && !sclr. It is combinational.
- On accept, the block latches the following:
  - `dir` <= `cmd_steps` < 0.
  - `remain` <= |`cmd_steps|` (the most negative value gives 2^(STEPS_WIDTH-1), which fits unsigned).
  - Effective period P = max(`cmd_period`, 2·PULSE_LEN).
- If `cmd_steps` == 0: no state change, `dir` unchanged, `done` pulses next cycle, `busy` stays 0.
- IDLE→SETUP: on accept with nonzero steps. SETUP lasts DIR_SETUP clocks.
- SETUP→HIGH:
  - `step` <= 1.
  - `pos` <= `pos` + 1 (dir 0) or − 1 (dir 1).
  - `remain` <= `remain` − 1.
- HIGH lasts PULSE_LEN clocks, then →LOW with `step` <= 0.
- LOW lasts P − PULSE_LEN clocks. At its end:
  - If `remain` ≠ 0: →HIGH (same updates as SETUP→HIGH).
  - Else: →IDLE, with `done` <= 1 and `busy` <= 0.
- `dir` changes only on accept. It holds its value between commands.
- Abort (`sclr` = 1):
  - In SETUP or LOW: →IDLE on the next edge. `aborted` pulses, `remain` <= 0, `busy` <= 0.
  - In HIGH: the pulse completes its full PULSE_LEN first, then →IDLE with `aborted`. No runt pulses are ever emitted.
  - `sclr` is sampled continuously; a single-cycle `sclr` during HIGH is remembered until the pulse ends.
  - `pos` is not cleared by `sclr`. A step whose rise occurred stays counted.
  - In IDLE, `sclr` only blocks acceptance.
- `aclr` at any time forces IDLE immediately. All outputs go to reset values; any step pulse is truncated.

## Timing
- Reset values:
  - `step` 0, `dir` 0, `busy` 0, `done` 0, `aborted` 0.
  - `remain` 0, `pos` 0, state IDLE. `cmd_ready` = !sclr.
- Cycle 0 = handshake cycle. `dir` and `busy` are valid from cycle 1.
- Step k (0-based) rises at cycle DIR_SETUP + 1 + k·P. It is high for PULSE_LEN cycles.
- `pos` and `remain` update in the same cycle `step` rises.
- `done` is high at cycle DIR_SETUP + 1 + N·P. In that cycle:
  - `busy` = 0 and `cmd_ready` = 1.
  - A back-to-back command is accepted, so its `dir` is valid one cycle later.
- Busy duration = DIR_SETUP + N·P cycles.
- Counters: the period/phase counter is PERIOD_WIDTH+1 bits, to hold 2·PULSE_LEN. Arithmetic is unsigned, with no overflow for legal parameters.

## Test plan
- PULSE_LEN=2, DIR_SETUP=4, cmd_steps=3, cmd_period=10 → step rises cycles 5, 15, 25 (high 2 cycles each), dir=0, pos 0→3, remain 3→0, done at cycle 35, busy cycles 1–34.
- Then cmd_steps=−2, cmd_period=10 → dir=1 from cycle 1, step rises at 5 and 15, pos 3→2→1, done at 25.
- cmd_steps=2, cmd_period=1 → P clamped to 4: rises at 5 and 9, done at 13.
- cmd_steps=0 → done at cycle 1, step never rises, busy 0, dir unchanged.
- cmd_steps=5, period 10, single-cycle sclr at cycle 16 (during HIGH of step 1) → step stays high through cycle 16, aborted at cycle 17, no further rises, pos=2, remain=0. Separately, sclr during LOW at cycle 20 → aborted at 21.
- cmd_valid held high with two queued commands → second accepted in the first's done cycle, with no idle gap. Then aclr during HIGH → step, busy, pos, and dir drop to 0 immediately, and cmd_ready is high after release.
